// File: rtl/line_fifo_ctrl_if.sv
// line_fifo_ctrl_if: event and status bundle between the line-buffer bank scheduler and its writer/reader stages
//   frmStart, frmEnd, wrtJmp, rdJmp : one-cycle event pulses into the scheduler
//   wrBank, rdBankTop, rdBankBot     : bank selects for the writer and the two read lines
//   fifoNum, rdValid, lastPair       : fill level and reader qualification
//   ovf, udf                         : sticky error flags
//   dropCnt, frmLines                : statistics, present only with LINE_FIFO_STAT_EN
//   modport master: event source (writer/reader side); modport slave: the scheduler
interface line_fifo_ctrl_if #(
   parameter int PTR_WIDTH       = 2,
   parameter int CNT_WIDTH       = 3,
   parameter int INPUT_RES_WIDTH = 10
);
   logic                 frmStart;
   logic                 frmEnd;
   logic                 wrtJmp;
   logic                 rdJmp;
   logic [PTR_WIDTH-1:0] wrBank;
   logic [PTR_WIDTH-1:0] rdBankTop;
   logic [PTR_WIDTH-1:0] rdBankBot;
   logic [CNT_WIDTH-1:0] fifoNum;
   logic                 rdValid;
   logic                 lastPair;
   logic                 ovf;
   logic                 udf;
`ifdef LINE_FIFO_STAT_EN
   logic [15:0]                dropCnt;
   logic [INPUT_RES_WIDTH-1:0] frmLines;
   modport master (output frmStart, frmEnd, wrtJmp, rdJmp,
                   input  wrBank, rdBankTop, rdBankBot, fifoNum, rdValid, lastPair, ovf, udf, dropCnt, frmLines);
   modport slave  (input  frmStart, frmEnd, wrtJmp, rdJmp,
                   output wrBank, rdBankTop, rdBankBot, fifoNum, rdValid, lastPair, ovf, udf, dropCnt, frmLines);
`else
   modport master (output frmStart, frmEnd, wrtJmp, rdJmp,
                   input  wrBank, rdBankTop, rdBankBot, fifoNum, rdValid, lastPair, ovf, udf);
   modport slave  (input  frmStart, frmEnd, wrtJmp, rdJmp,
                   output wrBank, rdBankTop, rdBankBot, fifoNum, rdValid, lastPair, ovf, udf);
`endif
endinterface

// File: rtl/line_fifo_ctrl.sv
// line_fifo_ctrl: bank scheduler for the scaler line-buffer FIFO (writer commits lines, reader releases the older of two)
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : line_fifo_ctrl_if.slave carrying events in and bank selects/fill/flags out
//   Optional LINE_FIFO_STAT_EN adds dropCnt (ignored writes, saturating) and frmLines (accepted writes this frame).
module line_fifo_ctrl #(
   parameter int FIFO_DEPTH      = 4,
   parameter int PTR_WIDTH       = 2,
   parameter int CNT_WIDTH       = 3,
   parameter int INPUT_RES_WIDTH = 10
) (
   input logic             clk,
   input logic             rst_n,
   line_fifo_ctrl_if.slave bus
);
   localparam logic [CNT_WIDTH-1:0] FULL = CNT_WIDTH'(FIFO_DEPTH);
   logic [PTR_WIDTH-1:0] wr_ptr, rd_ptr;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 frm_done, ovf, udf;
   logic                 wr_ok, rd_ok;
   // a write into a full FIFO is still legal when the same-cycle read frees the bank it lands in
   assign wr_ok = bus.wrtJmp & ((cnt != FULL) | bus.rdJmp);
   assign rd_ok = bus.rdJmp & (cnt != '0);
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         frm_done <= 1'b0;
         ovf      <= 1'b0;
         udf      <= 1'b0;
      end else if (bus.frmStart) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         cnt      <= '0;
         frm_done <= 1'b0;
      end else begin
         wr_ptr   <= wr_ptr + PTR_WIDTH'(wr_ok);
         rd_ptr   <= rd_ptr + PTR_WIDTH'(rd_ok);
         cnt      <= cnt + CNT_WIDTH'(wr_ok) - CNT_WIDTH'(rd_ok);
         frm_done <= frm_done | bus.frmEnd;
         ovf      <= ovf | (bus.wrtJmp & ~wr_ok);
         udf      <= udf | (bus.rdJmp & ~rd_ok);
      end
   assign bus.wrBank    = wr_ptr;
   assign bus.rdBankTop = rd_ptr;
   assign bus.rdBankBot = rd_ptr + PTR_WIDTH'(1);
   assign bus.fifoNum   = cnt;
   assign bus.lastPair  = frm_done & (cnt == CNT_WIDTH'(1));
   assign bus.rdValid   = (cnt >= CNT_WIDTH'(2)) | bus.lastPair;
   assign bus.ovf       = ovf;
   assign bus.udf       = udf;
`ifdef LINE_FIFO_STAT_EN
   logic [15:0]                drop_cnt;
   logic [INPUT_RES_WIDTH-1:0] frm_lines;
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         drop_cnt  <= '0;
         frm_lines <= '0;
      end else if (bus.frmStart) begin
         frm_lines <= '0;
      end else begin
         drop_cnt  <= drop_cnt + 16'((bus.wrtJmp & ~wr_ok) & (drop_cnt != 16'hFFFF));
         frm_lines <= frm_lines + INPUT_RES_WIDTH'(wr_ok);
      end
   assign bus.dropCnt  = drop_cnt;
   assign bus.frmLines = frm_lines;
`endif
endmodule

// File: tb/tb_line_fifo_ctrl.sv
// tb_line_fifo_ctrl: directed self-checking bench for line_fifo_ctrl
module tb_line_fifo_ctrl;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   errors = 0;
   int   checks = 0;
   line_fifo_ctrl_if #(.PTR_WIDTH(2), .CNT_WIDTH(3), .INPUT_RES_WIDTH(10)) bus ();
   line_fifo_ctrl #(.FIFO_DEPTH(4), .PTR_WIDTH(2), .CNT_WIDTH(3), .INPUT_RES_WIDTH(10)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask
   task automatic step(input logic fs, input logic fe, input logic w, input logic r);
      @(negedge clk);
      bus.frmStart = fs;
      bus.frmEnd   = fe;
      bus.wrtJmp   = w;
      bus.rdJmp    = r;
      @(posedge clk);
      #1;
      bus.frmStart = 1'b0;
      bus.frmEnd   = 1'b0;
      bus.wrtJmp   = 1'b0;
      bus.rdJmp    = 1'b0;
   endtask
   task automatic do_reset();
      rst_n = 1'b0;
      #3;
      @(negedge clk);
      rst_n = 1'b1;
   endtask
   task automatic check_reset_vals(input string tag);
      check({tag, ".wrBank"}, 32'(bus.wrBank), 0);
      check({tag, ".rdBankTop"}, 32'(bus.rdBankTop), 0);
      check({tag, ".rdBankBot"}, 32'(bus.rdBankBot), 1);
      check({tag, ".fifoNum"}, 32'(bus.fifoNum), 0);
      check({tag, ".rdValid"}, 32'(bus.rdValid), 0);
      check({tag, ".lastPair"}, 32'(bus.lastPair), 0);
      check({tag, ".ovf"}, 32'(bus.ovf), 0);
      check({tag, ".udf"}, 32'(bus.udf), 0);
   endtask
   initial begin
      bus.frmStart = 1'b0;
      bus.frmEnd   = 1'b0;
      bus.wrtJmp   = 1'b0;
      bus.rdJmp    = 1'b0;
      #12;
      check_reset_vals("rst");
      do_reset();
      // two commits; rdValid after second
      step(0, 0, 1, 0);
      check("w1.fifoNum", 32'(bus.fifoNum), 1);
      check("w1.rdValid", 32'(bus.rdValid), 0);
      step(0, 0, 1, 0);
      check("w2.fifoNum", 32'(bus.fifoNum), 2);
      check("w2.rdValid", 32'(bus.rdValid), 1);
      check("w2.wrBank", 32'(bus.wrBank), 2);
      check("w2.rdBankTop", 32'(bus.rdBankTop), 0);
      check("w2.rdBankBot", 32'(bus.rdBankBot), 1);
      // fill then overflow
      step(0, 0, 1, 0);
      step(0, 0, 1, 0);
      check("full.fifoNum", 32'(bus.fifoNum), 4);
      check("full.wrBank", 32'(bus.wrBank), 0);
      check("full.ovf", 32'(bus.ovf), 0);
      step(0, 0, 1, 0);
      check("ovf.fifoNum", 32'(bus.fifoNum), 4);
      check("ovf.wrBank", 32'(bus.wrBank), 0);
      check("ovf.ovf", 32'(bus.ovf), 1);
`ifdef LINE_FIFO_STAT_EN
      check("ovf.dropCnt", 32'(bus.dropCnt), 1);
      check("ovf.frmLines", 32'(bus.frmLines), 4);
`endif
      // full with simultaneous write and read
      do_reset();
      repeat (4) step(0, 0, 1, 0);
      step(0, 0, 1, 1);
      check("wr_full.fifoNum", 32'(bus.fifoNum), 4);
      check("wr_full.rdBankTop", 32'(bus.rdBankTop), 1);
      check("wr_full.rdBankBot", 32'(bus.rdBankBot), 2);
      check("wr_full.wrBank", 32'(bus.wrBank), 1);
      check("wr_full.ovf", 32'(bus.ovf), 0);
      // legal simultaneous pair mid-level
      step(0, 0, 0, 1);
      step(0, 0, 1, 1);
      check("wr_mid.fifoNum", 32'(bus.fifoNum), 3);
      check("wr_mid.rdBankTop", 32'(bus.rdBankTop), 3);
      check("wr_mid.wrBank", 32'(bus.wrBank), 2);
`ifdef LINE_FIFO_STAT_EN
      check("wr_mid.frmLines", 32'(bus.frmLines), 6);
      check("wr_mid.dropCnt", 32'(bus.dropCnt), 0);
`endif
      // end-of-frame single line
      step(1, 0, 0, 0);
      check("fs.fifoNum", 32'(bus.fifoNum), 0);
      check("fs.wrBank", 32'(bus.wrBank), 0);
      step(0, 0, 1, 0);
      check("one.rdValid", 32'(bus.rdValid), 0);
      check("one.lastPair", 32'(bus.lastPair), 0);
      step(0, 1, 0, 0);
      check("fe.rdValid", 32'(bus.rdValid), 1);
      check("fe.lastPair", 32'(bus.lastPair), 1);
      step(0, 0, 0, 1);
      check("fe_rd.fifoNum", 32'(bus.fifoNum), 0);
      check("fe_rd.rdValid", 32'(bus.rdValid), 0);
      check("fe_rd.lastPair", 32'(bus.lastPair), 0);
      check("fe_rd.rdBankTop", 32'(bus.rdBankTop), 1);
      check("fe_rd.udf", 32'(bus.udf), 0);
      // underflow at reset state, then frmStart over a write
      do_reset();
      step(0, 0, 0, 1);
      check("udf.udf", 32'(bus.udf), 1);
      check("udf.fifoNum", 32'(bus.fifoNum), 0);
      check("udf.rdBankTop", 32'(bus.rdBankTop), 0);
      repeat (3) step(0, 0, 1, 0);
      check("w3.fifoNum", 32'(bus.fifoNum), 3);
      check("w3.wrBank", 32'(bus.wrBank), 3);
      step(1, 0, 1, 0);
      check("fsw.wrBank", 32'(bus.wrBank), 0);
      check("fsw.rdBankTop", 32'(bus.rdBankTop), 0);
      check("fsw.fifoNum", 32'(bus.fifoNum), 0);
      check("fsw.udf", 32'(bus.udf), 1);
`ifdef LINE_FIFO_STAT_EN
      check("fsw.frmLines", 32'(bus.frmLines), 0);
`endif
      // write and read together while empty
      step(0, 0, 1, 1);
      check("wr_empty.fifoNum", 32'(bus.fifoNum), 1);
      check("wr_empty.wrBank", 32'(bus.wrBank), 1);
      check("wr_empty.rdBankTop", 32'(bus.rdBankTop), 0);
      // build ovf and level 3, then async reset mid-stream
      repeat (4) step(0, 0, 1, 0);
      check("pre.ovf", 32'(bus.ovf), 1);
      step(0, 1, 0, 1);
      check("pre.fifoNum", 32'(bus.fifoNum), 3);
      rst_n = 1'b0;
      #1;
      check_reset_vals("async");
`ifdef LINE_FIFO_STAT_EN
      check("async.dropCnt", 32'(bus.dropCnt), 0);
      check("async.frmLines", 32'(bus.frmLines), 0);
`endif
      @(negedge clk);
      rst_n = 1'b1;
      step(0, 0, 1, 0);
      check("post.fifoNum", 32'(bus.fifoNum), 1);
      check("post.lastPair", 32'(bus.lastPair), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/line_fifo_ctrl.md
# line_fifo_ctrl

Bank scheduler for the scaler's line-buffer RAM FIFO. It arbitrates FIFO_DEPTH line banks between the input writer and the interpolation reader. The writer is the input control stage, which commits a line with its jmp pulse. The reader is the coefficient/interpolation stage, which needs two adjacent lines and releases the older one when done. The block tracks fill level, drives the bank selects for write and for the top/bottom read lines, and reports fill to the input stage as fifoNum so input is throttled when all banks hold unread lines.

## Interface
- FIFO_DEPTH, 4, number of line banks; power of two, 2..8
- PTR_WIDTH, 2, log2(FIFO_DEPTH)
- CNT_WIDTH, 3, PTR_WIDTH+1
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- frmStart  in  1  one-cycle pulse, new frame; flushes all banks
- frmEnd  in  1  one-cycle pulse, writer delivered last line of frame
- wrtJmp  in  1  one-cycle pulse, writer finished current line (jmp from input control)
- rdJmp  in  1  one-cycle pulse, reader finished with top line; release it
- wrBank  out  PTR_WIDTH  bank the writer fills now
- rdBankTop  out  PTR_WIDTH  oldest unread bank
- rdBankBot  out  PTR_WIDTH  rdBankTop+1 mod FIFO_DEPTH
- fifoNum  out  CNT_WIDTH  committed unread lines, 0..FIFO_DEPTH
- rdValid  out  1  reader may process rdBankTop/rdBankBot
- lastPair  out  1  rdValid owed to frmEnd with only one line left; reader reuses top as bottom
- ovf  out  1  sticky, wrtJmp arrived while full
- udf  out  1  sticky, rdJmp arrived while empty

## Operation
- Internal state: wrPtr, rdPtr (PTR_WIDTH, natural wrap), cnt (CNT_WIDTH), frmDone flag.
- wrtJmp with cnt<FIFO_DEPTH: wrPtr+1, cnt+1.
- wrtJmp with cnt==FIFO_DEPTH: ignored, no pointer or count change; ovf set.
- rdJmp with cnt>0: rdPtr+1, cnt-1.
- rdJmp with cnt==0: ignored; udf set.
- wrtJmp and rdJmp in the same cycle, both legal: both pointers advance and cnt is unchanged.
- wrtJmp and rdJmp in the same cycle with cnt==FIFO_DEPTH: both accepted, since the write lands in the bank the read frees. cnt stays FIFO_DEPTH and ovf is not set.
- wrtJmp and rdJmp in the same cycle with cnt==0: write accepted, read ignored, udf set, cnt=1.
- frmEnd sets frmDone. frmStart clears wrPtr, rdPtr, cnt and frmDone. ovf and udf are cleared only by reset.
- frmStart has priority over every same-cycle event; coincident wrtJmp/rdJmp/frmEnd are discarded.
- rdValid = (cnt>=2) | (frmDone & cnt==1).
- lastPair = frmDone & cnt==1.
- wrBank=wrPtr, rdBankTop=rdPtr, rdBankBot=rdPtr+1 (wraps).
- fifoNum=cnt. The input stage halts h_valid when fifoNum==FIFO_DEPTH.

## Timing
- All outputs are registered and update on the clk edge that samples the event; there are no combinational paths from inputs to outputs.
- An event in cycle N is visible on the outputs in cycle N+1.
- A back-to-back pulse every cycle is legal for all inputs.
- Reset values: wrBank=0, rdBankTop=0, rdBankBot=1, fifoNum=0, rdValid=0, lastPair=0, ovf=0, udf=0; frmDone=0.
- Reset asserted mid-frame returns the block to the reset values immediately (asynchronous); the first clk edge after rst_n rises may accept events.
- Counter arithmetic is unsigned. Pointers wrap modulo FIFO_DEPTH with no explicit compare. cnt never exceeds FIFO_DEPTH or goes below 0.

## Configuration
- LINE_FIFO_STAT_EN defined: adds outputs dropCnt (16 bit) and frmLines (INPUT_RES_WIDTH, default 10).
  - dropCnt counts ignored wrtJmp pulses and saturates at 16'hFFFF.
  - frmLines counts accepted wrtJmp pulses since the last frmStart.
  - frmStart clears frmLines only; reset clears both.
- LINE_FIFO_STAT_EN undefined: the ports and counters are absent and the remaining behaviour is identical.

## Test plan
- Reset, then 2 wrtJmp pulses -> fifoNum 1 then 2; rdValid rises the cycle after the 2nd pulse; wrBank=2, rdBankTop=0, rdBankBot=1.
- 4 wrtJmp pulses, then a 5th -> fifoNum stays 4, wrBank stays 0, ovf=1 (and dropCnt=1 with LINE_FIFO_STAT_EN).
- Full FIFO with wrtJmp and rdJmp in the same cycle -> fifoNum 4, rdBankTop=1, wrBank=1, ovf=0.
- 1 wrtJmp, then frmEnd -> rdValid=1, lastPair=1; one rdJmp -> fifoNum 0, rdValid=0, lastPair=0.
- rdJmp at reset state -> udf=1, fifoNum 0, rdBankTop 0. Then 3 wrtJmp plus frmStart coincident with a wrtJmp -> all pointers 0, fifoNum 0, udf still 1.
- rst_n pulled low mid-stream with fifoNum=3 -> all outputs return to reset values without waiting for a clock edge; ovf and udf are cleared.
